fxp_div_top: RTL and testbench

Sequential unsigned fixed-point divider computing Q = A / B on 10-bit operands in Q6.4 format: 6 integer bits and 4 fractional bits, so 16 = 1.0. It is a standalone arithmetic block with a start/busy/valid handshake. It flags overflow when the quotient does not fit in Q6.4 and flags division by zero. It uses a restoring shift-subtract algorithm, one quotient bit per clock.

---
 rtl/fxp_div_pkg.sv | 12 +
 rtl/fxp_div_datapath.sv | 77 +++++++
 rtl/fxp_div_top.sv | 115 +++++++++++
 tb/tb_fxp_div_top.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fxp_div_pkg.sv
// Shared constants and types for the Q6.4 restoring divider.
package fxp_div_pkg;

  localparam int W  = 10;
  localparam int F  = 4;
  localparam int QW = W + F;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] Q_SAT = 10'h3FF;

endpackage

// File: rtl/fxp_div_datapath.sv
// Restoring shift-subtract datapath: dividend, remainder, quotient registers
// and a down-counter; one quotient bit per step.
module fxp_div_datapath #(
  parameter int W = 10,
  parameter int F = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [W+F-1:0] quo_next
);
  import fxp_div_pkg::*;

  localparam int DW = W + F;
  localparam int CW = $clog2(DW);

  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    rem_shift;
  logic [W+1:0]  trial;
  logic          qbit;

  // The remainder is always below the divisor, so its top bit is zero before the shift.
  always_comb begin
    rem_shift = {rem_q[W-1:0], dvd_q[DW-1]};
    trial     = {1'b0, rem_shift} - {2'b00, div_q};
    qbit      = ~trial[W+1];

    dvd_d = dvd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    div_d = div_q;
    cnt_d = cnt_q;

    if (load) begin
      dvd_d = {a, {F{1'b0}}};
      quo_d = '0;
      rem_d = '0;
      div_d = b;
      cnt_d = CW'(DW - 1);
    end else if (step) begin
      dvd_d = {dvd_q[DW-2:0], 1'b0};
      quo_d = {quo_q[DW-2:0], qbit};
      rem_d = qbit ? trial[W:0] : rem_shift;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // Quotient including the bit produced this step, so the top can register it on the final edge.
  assign done     = (cnt_q == '0);
  assign quo_next = {quo_q[DW-2:0], qbit};

endmodule

// File: rtl/fxp_div_top.sv
// Sequential unsigned Q6.4 divider with start/busy/valid handshake,
// saturation on overflow and divide-by-zero flag.
module fxp_div_top #(
  parameter int W = 10,
  parameter int F = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic         busy,
  output logic         valid,
  output logic         ov,
  output logic         dvz
);
  import fxp_div_pkg::*;

  localparam int DW = W + F;

  state_t       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         ov_q, ov_d;
  logic         dvz_q, dvz_d;

  logic          b_zero;
  logic          dp_load;
  logic          dp_step;
  logic          dp_done;
  logic [DW-1:0] dp_quo;
  logic          quo_ovf;

  assign b_zero  = (B == '0);
  assign dp_load = start && (state_q != RUN) && !b_zero;
  assign dp_step = (state_q == RUN);
  assign quo_ovf = |dp_quo[DW-1:W];

  fxp_div_datapath #(.W(W), .F(F)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .step     (dp_step),
    .a        (A),
    .b        (B),
    .done     (dp_done),
    .quo_next (dp_quo)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    ov_d    = ov_q;
    dvz_d   = dvz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          valid_d = 1'b0;
          ov_d    = 1'b0;
          dvz_d   = 1'b0;
          if (b_zero) begin
            state_d = DONE;
            valid_d = 1'b1;
            dvz_d   = 1'b1;
            q_d     = Q_SAT;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // Counter at zero means this edge performs the last iteration.
        if (dp_done) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          ov_d    = quo_ovf;
          q_d     = quo_ovf ? Q_SAT : dp_quo[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ov_q    <= ov_d;
      dvz_q   <= dvz_d;
    end
  end

  assign Q     = q_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign ov    = ov_q;
  assign dvz   = dvz_q;

endmodule

// File: tb/tb_fxp_div_top.sv
// Scoreboard bench for fxp_div_top: stimulus pushes expected results, a
// monitor pops and compares on each rising edge of valid.
module tb_fxp_div_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] A = '0;
  logic [9:0] B = '0;
  logic [9:0] Q;
  logic       busy, valid, ov, dvz;

  typedef struct packed {
    logic [9:0] q;
    logic       ov;
    logic       dvz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fxp_div_top dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .busy  (busy),
    .valid (valid),
    .ov    (ov),
    .dvz   (dvz)
  );

  function automatic exp_t model(input logic [9:0] a, input logic [9:0] b);
    exp_t e;
    int   qf;
    if (b == 0) begin
      e.q = 10'h3FF; e.ov = 1'b0; e.dvz = 1'b1;
    end else begin
      qf = (int'(a) * 16) / int'(b);
      e.dvz = 1'b0;
      if (qf > 1023) begin
        e.q = 10'h3FF; e.ov = 1'b1;
      end else begin
        e.q = qf[9:0]; e.ov = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per completed result.
  initial begin
    logic v_last;
    exp_t e;
    v_last = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !v_last) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got Q=%0d with no pending transaction", Q);
        end else begin
          e = sb.pop_front();
          $display("result Q=%0d ov=%0b dvz=%0b (expected Q=%0d ov=%0b dvz=%0b)",
                   Q, ov, dvz, e.q, e.ov, e.dvz);
          check("Q", Q, e.q);
          check("ov", ov, e.ov);
          check("dvz", dvz, e.dvz);
        end
      end
      v_last = valid;
    end
  end

  // Launch one division; glitch=1 re-pulses start mid-run with other operands.
  task automatic run_div(input logic [9:0] a, input logic [9:0] b, input bit glitch);
    int cyc;
    bit busy_seen;
    sb.push_back(model(a, b));
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = '0; B = '0;
    cyc = 0;
    busy_seen = busy;
    if (b != 0) check("valid_cleared_on_start", valid, 0);
    while (!valid && cyc < 40) begin
      if (glitch && cyc == 4) begin
        A = 10'd16; B = 10'd8; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      busy_seen = busy_seen | busy;
    end
    start = 1'b0;
    check("latency", cyc, (b == 0) ? 0 : 14);
    check("busy_seen", busy_seen, (b != 0) ? 1 : 0);
    check("busy_low_at_done", busy, 0);
  endtask

  // Start a run and hit reset in its 7th cycle; no result is expected.
  task automatic abort_run(input logic [9:0] a, input logic [9:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {Q, busy, valid, ov, dvz}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_result_after_abort", valid, 0);
  endtask

  initial begin
    logic [9:0] bsel [3];
    bsel[0] = 10'd8; bsel[1] = 10'd16; bsel[2] = 10'd24;

    repeat (3) @(negedge clk);
    check("reset_outputs", {Q, busy, valid, ov, dvz}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(10'h350, 10'd0, 1'b0);
    run_div(10'd175, 10'd16, 1'b0);
    run_div(10'd794, 10'd8, 1'b0);
    run_div(10'd426, 10'd24, 1'b0);
    run_div(10'd16, 10'd24, 1'b0);
    run_div(10'd19, 10'd24, 1'b0);
    run_div(10'd426, 10'd24, 1'b1);
    abort_run(10'd426, 10'd24);
    run_div(10'd19, 10'd24, 1'b0);
    run_div(10'd175, 10'd16, 1'b0);
    run_div(10'd794, 10'd8, 1'b0);
    run_div(10'd1023, 10'd1023, 1'b0);
    run_div(10'd63, 10'd1, 1'b0);

    for (int i = 0; i < 100; i++) begin
      run_div(10'($urandom_range(0, 1023)), bsel[$urandom_range(0, 2)], 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
